// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_scan_pkg
//  Description : Shared types, constants and channel-walk helpers for the
//                4:1 mux select sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

  localparam int NCH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Lowest enabled channel; returns 0 for an empty mask (never used that way).
  function automatic logic [1:0] first_en(input logic [NCH-1:0] mask);
    logic [1:0] res;
    res = 2'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) res = 2'(i);
    end
    return res;
  endfunction

  // Next enabled channel strictly above cur; returns cur when none exists.
  function automatic logic [1:0] next_en(input logic [NCH-1:0] mask,
                                         input logic [1:0]     cur);
    logic [1:0] res;
    res = cur;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) res = 2'(i);
    end
    return res;
  endfunction

  // True when cur is the highest enabled channel, i.e. the sweep ends here.
  function automatic logic is_last(input logic [NCH-1:0] mask,
                                   input logic [1:0]     cur);
    logic res;
    res = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (mask[i] && (i > int'(cur))) res = 1'b0;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_cnt
//  Description : Loadable down-counter timing how long each select is held.
//                o_zero flags the final cycle of a dwell: the count reaches
//                zero on the coming edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module dwell_cnt #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  input  logic               i_en,
  output logic               o_zero
);

  logic [DWELL_W-1:0] r_cnt;

  // Load takes priority over counting down; count stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DWELL_W'(1);
    end
  end

  assign o_zero = (r_cnt <= DWELL_W'(1));

endmodule
`default_nettype wire

// File: rtl/mux_sel_scan.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_scan
//  Description : Walks the 4:1 mux select over enabled channels, holds each
//                for a programmable dwell, samples f at the end of each dwell
//                and assembles a 4-bit frame per sweep (single/continuous).
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_scan
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_mode,
  input  logic [NCH-1:0]     i_en_mask,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_f_in,
  output logic [1:0]         o_sel,
  output logic               o_busy,
  output logic               o_done,
  output logic [NCH-1:0]     o_frame
);

  state_t             r_state;
  logic [1:0]         r_sel;
  logic [NCH-1:0]     r_mask;
  logic [DWELL_W-1:0] r_d;
  logic [NCH-1:0]     r_work;
  logic [NCH-1:0]     r_frame;
  logic               r_done;

  state_t             w_state_nxt;
  logic [1:0]         w_sel_nxt;
  logic [NCH-1:0]     w_mask_nxt;
  logic [DWELL_W-1:0] w_d_nxt;
  logic [NCH-1:0]     w_work_nxt;
  logic [NCH-1:0]     w_frame_nxt;
  logic               w_done_nxt;
  logic               w_load;
  logic [DWELL_W-1:0] w_load_val;
  logic [DWELL_W-1:0] w_dwell_eff;
  logic [NCH-1:0]     w_cap;
  logic               w_zero;

  // A programmed dwell of zero behaves as a single cycle.
  assign w_dwell_eff = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;

  dwell_cnt #(
    .DWELL_W (DWELL_W)
  ) u_dwell_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (r_state == SCAN),
    .o_zero     (w_zero)
  );

  // Next-state, select walk, capture and frame assembly.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_mask_nxt  = r_mask;
    w_d_nxt     = r_d;
    w_work_nxt  = r_work;
    w_frame_nxt = r_frame;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_load_val  = r_d;
    w_cap       = r_work;
    w_cap[r_sel] = i_f_in;

    case (r_state)
      IDLE: begin
        if (i_start && !i_stop && (i_en_mask != '0)) begin
          w_mask_nxt  = i_en_mask;
          w_d_nxt     = w_dwell_eff;
          w_sel_nxt   = first_en(i_en_mask);
          w_load      = 1'b1;
          w_load_val  = w_dwell_eff;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (i_stop) begin
          // Abort wins over a sweep finishing on the same edge.
          w_work_nxt  = '0;
          w_state_nxt = IDLE;
        end else if (w_zero) begin
          if (!is_last(r_mask, r_sel)) begin
            w_work_nxt = w_cap;
            w_sel_nxt  = next_en(r_mask, r_sel);
            w_load     = 1'b1;
            w_load_val = r_d;
          end else begin
            w_frame_nxt = w_cap & r_mask;
            w_done_nxt  = 1'b1;
            w_work_nxt  = '0;
            if (!i_mode || (i_en_mask == '0)) begin
              w_state_nxt = IDLE;
            end else begin
              // Back-to-back sweep with freshly sampled mask and dwell.
              w_mask_nxt = i_en_mask;
              w_d_nxt    = w_dwell_eff;
              w_sel_nxt  = first_en(i_en_mask);
              w_load     = 1'b1;
              w_load_val = w_dwell_eff;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= 2'b00;
      r_mask  <= '0;
      r_d     <= '0;
      r_work  <= '0;
      r_frame <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_mask  <= w_mask_nxt;
      r_d     <= w_d_nxt;
      r_work  <= w_work_nxt;
      r_frame <= w_frame_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_sel   = r_sel;
  assign o_busy  = (r_state == SCAN);
  assign o_done  = r_done;
  assign o_frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_sel_scan
//  Description : Directed bench for mux_sel_scan with a frame scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_scan;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode;
  logic [3:0] en_mask;
  logic [7:0] dwell;
  logic       f_in;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [3:0] frame;

  // Mux data inputs {d, c, b, a}; f is the combinational 4:1 mux output.
  logic [3:0] mux_in;
  assign f_in = mux_in[sel];

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_q[$];

  mux_sel_scan #(.DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (start),
    .i_stop    (stop),
    .i_mode    (mode),
    .i_en_mask (en_mask),
    .i_dwell   (dwell),
    .i_f_in    (f_in),
    .o_sel     (sel),
    .o_busy    (busy),
    .o_done    (done),
    .o_frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame monitor: every done pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got frame %0h expected no done at %0t", frame, $time);
      end else begin
        chk("frame", {4'b0, frame}, {4'b0, exp_q.pop_front()});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    en_mask = 4'b0; dwell = 8'd0; mux_in = 4'b0;
    #2;
    chk("rst_sel",   {6'b0, sel},   8'h00);
    chk("rst_busy",  {7'b0, busy},  8'h00);
    chk("rst_done",  {7'b0, done},  8'h00);
    chk("rst_frame", {4'b0, frame}, 8'h00);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Full single sweep: a=1 b=0 c=1 d=1, dwell 2.
    mux_in = 4'b1101; en_mask = 4'b1111; dwell = 8'd2; mode = 1'b0; start = 1'b1;
    exp_q.push_back(4'b1101);
    tick();
    start = 1'b0;
    chk("full_busy", {7'b0, busy}, 8'h01);
    for (int k = 0; k < 8; k++) begin
      chk("full_sel", {6'b0, sel}, 8'(k / 2));
      tick();
    end
    chk("full_done",     {7'b0, done}, 8'h01);
    chk("full_busy_end", {7'b0, busy}, 8'h00);
    tick();
    chk("full_done_pulse", {7'b0, done}, 8'h00);

    // Sparse mask with zero dwell; disabled channels read as 0.
    mux_in = 4'b1111; en_mask = 4'b0101; dwell = 8'd0; start = 1'b1;
    exp_q.push_back(4'b0101);
    tick();
    start = 1'b0;
    chk("sparse_sel0", {6'b0, sel}, 8'h00);
    tick();
    chk("sparse_sel2", {6'b0, sel}, 8'h02);
    chk("sparse_busy", {7'b0, busy}, 8'h01);
    tick();
    chk("sparse_done", {7'b0, done}, 8'h01);
    chk("sparse_idle", {7'b0, busy}, 8'h00);
    tick();

    // Continuous mode on channel 3, d toggled per sweep; last sweep in single mode.
    en_mask = 4'b1000; dwell = 8'd3; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 4; s++) begin
      mux_in = {s[0], 3'b000};
      exp_q.push_back({s[0], 3'b000});
      if (s == 3) mode = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("cont_sel", {6'b0, sel}, 8'h03);
        chk("cont_busy", {7'b0, busy}, (s == 3 && j == 2) ? 8'h00 : 8'h01);
        chk("cont_done", {7'b0, done}, (j == 2) ? 8'h01 : 8'h00);
      end
    end
    tick();
    // frame now 4'b1000

    // Stop after the first capture: no done, frame kept.
    mux_in = 4'b1111; en_mask = 4'b1111; dwell = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("stop_sel_pre", {6'b0, sel}, 8'h01);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy",  {7'b0, busy},  8'h00);
    chk("stop_done",  {7'b0, done},  8'h00);
    chk("stop_frame", {4'b0, frame}, 8'h08);
    tick();

    // Restart after stop begins at channel 0.
    mux_in = 4'b0010; en_mask = 4'b0011; dwell = 8'd1; start = 1'b1;
    exp_q.push_back(4'b0010);
    tick();
    start = 1'b0;
    chk("restart_sel0", {6'b0, sel}, 8'h00);
    tick();
    chk("restart_sel1", {6'b0, sel}, 8'h01);
    tick();
    chk("restart_done", {7'b0, done}, 8'h01);
    tick();

    // Start with empty mask is ignored.
    en_mask = 4'b0000; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("empty_busy", {7'b0, busy}, 8'h00);
    chk("empty_done", {7'b0, done}, 8'h00);

    // Start pulsed during SCAN does not disturb the channel order.
    mux_in = 4'b0100; en_mask = 4'b0110; dwell = 8'd1; start = 1'b1;
    exp_q.push_back(4'b0100);
    tick();
    chk("inscan_sel1", {6'b0, sel}, 8'h01);
    tick();
    start = 1'b0;
    chk("inscan_sel2", {6'b0, sel}, 8'h02);
    tick();
    chk("inscan_done", {7'b0, done}, 8'h01);
    chk("inscan_busy", {7'b0, busy}, 8'h00);
    tick();

    // Asynchronous reset between edges mid-sweep.
    mux_in = 4'b1111; en_mask = 4'b1111; dwell = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("pre_arst_sel", {6'b0, sel}, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sel",   {6'b0, sel},   8'h00);
    chk("arst_busy",  {7'b0, busy},  8'h00);
    chk("arst_done",  {7'b0, done},  8'h00);
    chk("arst_frame", {4'b0, frame}, 8'h00);
    tick();
    rst = 1'b0;
    tick(); tick();

    chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
